// File: rtl/if_tag_fifo_pkg.sv
// Shared constants for the IF tag FIFO: default geometry and tag bit layout.
package if_tag_fifo_pkg;

    // Defaults shared with the datapath's IF scratch parameters
    localparam int IF_DATA_WIDTH = 16;
    localparam int IF_DEPTH      = 16;
    localparam int IF_ADDR_LEN   = 4;
    localparam int IF_ROW_LEN_W  = 8;

    // Tagged word layout: {start, end, data}
    localparam int END_BIT   = IF_DATA_WIDTH;
    localparam int START_BIT = IF_DATA_WIDTH + 1;
    localparam int TAG_WIDTH = IF_DATA_WIDTH + 2;

    // Tag positions for a non-default data width
    function automatic int end_bit_of(input int dw);
        return dw;
    endfunction

    function automatic int start_bit_of(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/if_tag_fifo_if.sv
// Loader/datapath-facing bus of the IF tag FIFO.
interface if_tag_fifo_if
    import if_tag_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = IF_DATA_WIDTH,
    parameter int ADDR_LEN   = IF_ADDR_LEN,
    parameter int ROW_LEN_W  = IF_ROW_LEN_W
) ();

    logic                  clr;
    logic [ROW_LEN_W-1:0]  row_len;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  rd_en;
    logic [DATA_WIDTH+1:0] rd_data;
    logic                  empty;
    logic [ADDR_LEN:0]     count;
    logic                  overflow;
    logic                  underflow;

    // Loader + datapath side
    modport master (
        output clr, row_len, wr_en, wr_data, rd_en,
        input  full, rd_data, empty, count, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  clr, row_len, wr_en, wr_data, rd_en,
        output full, rd_data, empty, count, overflow, underflow
    );

endinterface

// File: rtl/if_tag_fifo_row_tagger.sv
// Column counter and row-length latch producing start/end tags per accepted write.
module if_row_tagger #(
    parameter int ROW_LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [ROW_LEN_W-1:0] row_len,
    input  logic                 wr_acc,
    output logic                 start_tag,
    output logic                 end_tag
);

    logic [ROW_LEN_W-1:0] col;
    logic [ROW_LEN_W-1:0] eff_len;
    logic [ROW_LEN_W-1:0] len_now;

    // At a row boundary the live row_len applies (0 treated as 1); mid-row the latched one
    always_comb begin
        len_now = eff_len;
        if (col == '0) begin
            len_now = (row_len == '0) ? ROW_LEN_W'(1) : row_len;
        end
    end

    assign start_tag = (col == '0);
    assign end_tag   = (col == len_now - ROW_LEN_W'(1));

    // Advance column on accepted writes, latching the row length on the first word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col     <= '0;
            eff_len <= ROW_LEN_W'(1);
        end else if (clr) begin
            col <= '0;
        end else if (wr_acc) begin
            if (col == '0) begin
                eff_len <= len_now;
            end
            col <= end_tag ? '0 : col + ROW_LEN_W'(1);
        end
    end

endmodule

// File: rtl/if_tag_fifo.sv
// Tagged first-word-fall-through IF FIFO feeding the PE datapath IF buffer port.
module if_tag_fifo
    import if_tag_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = IF_DATA_WIDTH,
    parameter int DEPTH      = IF_DEPTH,
    parameter int ADDR_LEN   = IF_ADDR_LEN,
    parameter int ROW_LEN_W  = IF_ROW_LEN_W
) (
    input  logic           clk,
    input  logic           rst,
    if_tag_fifo_if.slave   bus
);

    localparam int END_POS   = end_bit_of(DATA_WIDTH);
    localparam int START_POS = start_bit_of(DATA_WIDTH);
    localparam logic [ADDR_LEN:0] FULL_CNT = (ADDR_LEN+1)'(DEPTH);

    logic [DATA_WIDTH+1:0] mem [DEPTH];
    logic [ADDR_LEN-1:0]   wr_ptr;
    logic [ADDR_LEN-1:0]   rd_ptr;
    logic [ADDR_LEN:0]     count;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  start_tag;
    logic                  end_tag;
    logic [DATA_WIDTH+1:0] wr_word;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    // clr wins over both strobes in the same cycle
    assign wr_acc = bus.wr_en & ~full  & ~bus.clr;
    assign rd_acc = bus.rd_en & ~empty & ~bus.clr;

    if_row_tagger #(
        .ROW_LEN_W (ROW_LEN_W)
    ) u_tagger (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.clr),
        .row_len   (bus.row_len),
        .wr_acc    (wr_acc),
        .start_tag (start_tag),
        .end_tag   (end_tag)
    );

    // Assemble the stored entry {start, end, data}
    always_comb begin
        wr_word                       = '0;
        wr_word[DATA_WIDTH-1:0]       = bus.wr_data;
        wr_word[END_POS]              = end_tag;
        wr_word[START_POS]            = start_tag;
    end

    // Storage array; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.wr_en && full) begin
                overflow <= 1'b1;
            end
            if (bus.rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
    assign bus.rd_data   = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_if_tag_fifo.sv
// Self-checking bench for if_tag_fifo: queue-based reference model plus directed literals.
module tb_if_tag_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AL    = 4;
    localparam int RLW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   run_cmp = 1'b0;

    always #5 clk = ~clk;

    if_tag_fifo_if #(.DATA_WIDTH(DW), .ADDR_LEN(AL), .ROW_LEN_W(RLW)) bus ();

    if_tag_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_LEN   (AL),
        .ROW_LEN_W  (RLW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- reference model ----------------
    logic [DW+1:0] q[$];
    int            m_col = 0;
    int            m_len = 1;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_col = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (bus.clr) begin
            q.delete();
            m_col = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            int  sz;
            bit  do_wr;
            bit  do_rd;
            sz    = q.size();
            do_wr = bus.wr_en && (sz < DEPTH);
            do_rd = bus.rd_en && (sz > 0);
            if (bus.wr_en && sz == DEPTH) m_ovf = 1'b1;
            if (bus.rd_en && sz == 0)     m_unf = 1'b1;
            if (do_rd) void'(q.pop_front());
            if (do_wr) begin
                bit s;
                bit e;
                if (m_col == 0) m_len = (bus.row_len == 0) ? 1 : int'(bus.row_len);
                s = (m_col == 0);
                e = (m_col == m_len - 1);
                q.push_back({s, e, bus.wr_data});
                m_col = e ? 0 : m_col + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (run_cmp) begin
            logic [DW+1:0] exp_rd;
            exp_rd = (q.size() > 0) ? q[0] : '0;
            chk("empty",     64'(bus.empty),     64'(q.size() == 0));
            chk("full",      64'(bus.full),      64'(q.size() == DEPTH));
            chk("count",     64'(bus.count),     64'(q.size()));
            chk("rd_data",   64'(bus.rd_data),   64'(exp_rd));
            chk("overflow",  64'(bus.overflow),  64'(m_ovf));
            chk("underflow", 64'(bus.underflow), 64'(m_unf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pop_chk(input string name, input logic [DW+1:0] exp);
        chk(name, 64'(bus.rd_data), 64'(exp));
        bus.rd_en = 1'b1;
        cyc();
        bus.rd_en = 1'b0;
    endtask

    task automatic flush();
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
    endtask

    initial begin
        bus.clr = 1'b0; bus.row_len = '0; bus.wr_en = 1'b0;
        bus.wr_data = '0; bus.rd_en = 1'b0;
        run_cmp = 1'b1;
        cyc(); cyc();
        rst = 1'b1;
        cyc();

        // reset state
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full",  64'(bus.full),  64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_rd",    64'(bus.rd_data), 64'd0);
        chk("rst_flags", 64'({bus.overflow, bus.underflow}), 64'd0);

        // tagging with row_len=3
        bus.row_len = 8'd3;
        wr(16'h0011); wr(16'h0022); wr(16'h0033); wr(16'h0044);
        pop_chk("tag0", 18'h20011);
        pop_chk("tag1", 18'h00022);
        pop_chk("tag2", 18'h10033);
        pop_chk("tag3", 18'h20044);

        // row length change takes effect at next row boundary
        flush();
        bus.row_len = 8'd4;
        wr(16'h0001); wr(16'h0002);
        bus.row_len = 8'd2;
        wr(16'h0003); wr(16'h0004); wr(16'h0005); wr(16'h0006);
        pop_chk("rl1", 18'h20001);
        pop_chk("rl2", 18'h00002);
        pop_chk("rl3", 18'h00003);
        pop_chk("rl4", 18'h10004);
        pop_chk("rl5", 18'h20005);
        pop_chk("rl6", 18'h10006);

        // row_len=0 behaves as 1
        flush();
        bus.row_len = 8'd0;
        wr(16'hAAAA);
        pop_chk("rl0", 18'h3AAAA);

        // move pointers off zero, then fill across the wrap
        flush();
        bus.row_len = 8'd5;
        for (int i = 0; i < 3; i++) wr(16'h0050 + 16'(i));
        for (int i = 0; i < 3; i++) begin
            bus.rd_en = 1'b1; cyc(); bus.rd_en = 1'b0;
        end
        for (int i = 0; i < 16; i++) wr(16'h0100 + 16'(i));
        chk("fill_full",  64'(bus.full),  64'd1);
        chk("fill_count", 64'(bus.count), 64'd16);
        wr(16'hDEAD);
        chk("ovf_flag",  64'(bus.overflow), 64'd1);
        chk("ovf_count", 64'(bus.count),    64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 64'(bus.rd_data[DW-1:0]), 64'(16'h0100 + 16'(i)));
            bus.rd_en = 1'b1; cyc(); bus.rd_en = 1'b0;
        end
        chk("drain_empty", 64'(bus.empty), 64'd1);

        // simultaneous read/write while full
        flush();
        for (int i = 0; i < 16; i++) wr(16'h0200 + 16'(i));
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 16'hBEEF;
        cyc();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        chk("sim_full_count", 64'(bus.count),    64'd15);
        chk("sim_full_ovf",   64'(bus.overflow), 64'd1);
        chk("sim_full_head",  64'(bus.rd_data[DW-1:0]), 64'h0201);

        // simultaneous read/write while empty
        flush();
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 16'h1234;
        cyc();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        chk("sim_empty_count", 64'(bus.count),     64'd1);
        chk("sim_empty_unf",   64'(bus.underflow), 64'd1);

        // clr together with wr_en
        wr(16'h0301); wr(16'h0302);
        bus.clr = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 16'h0303;
        cyc();
        bus.clr = 1'b0; bus.wr_en = 1'b0;
        chk("clr_count", 64'(bus.count), 64'd0);
        chk("clr_flags", 64'({bus.overflow, bus.underflow}), 64'd0);

        // asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) wr(16'h0400 + 16'(i));
        chk("pre_rst_count", 64'(bus.count), 64'd5);
        #1 rst = 1'b0;
        #1;
        chk("arst_empty", 64'(bus.empty),   64'd1);
        chk("arst_count", 64'(bus.count),   64'd0);
        chk("arst_rd",    64'(bus.rd_data), 64'd0);
        cyc();
        rst = 1'b1;
        cyc();

        // randomized traffic in biased phases
        for (int blk = 0; blk < 16; blk++) begin
            int wp;
            int rp;
            wp = int'($urandom_range(10, 90));
            rp = int'($urandom_range(10, 90));
            for (int c = 0; c < 200; c++) begin
                bus.wr_en   = ($urandom_range(0, 99) < wp);
                bus.rd_en   = ($urandom_range(0, 99) < rp);
                bus.wr_data = 16'($urandom);
                bus.clr     = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 19) == 0) bus.row_len = 8'($urandom_range(0, 5));
                cyc();
            end
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr = 1'b0;
        cyc();
        @(negedge clk);
        run_cmp = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_tag_fifo.md
Name: if_tag_fifo

Overview:
- Input-feature (IF) stream buffer that sits directly upstream of the PE datapath and drives its IF buffer interface (data, empty flag, read strobe).
- Accepts raw IF words from the loader and tags each word with start-of-row and end-of-row flags from a programmable row length.
- Stores tagged words in a circular FIFO and presents the head word first-word-fall-through, so the datapath can sample it combinationally in the same cycle it asserts read.

Parameters:
- DATA_WIDTH, 16, IF word width; equals the datapath's IF scratch width.
- DEPTH, 16, FIFO entries; power of two.
- ADDR_LEN, 4, log2(DEPTH).
- ROW_LEN_W, 8, width of the row-length field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush.
- row_len  in  ROW_LEN_W  words per IF row.
- wr_en  in  1  loader write request.
- wr_data  in  DATA_WIDTH  loader IF word.
- full  out  1  no free entry.
- rd_en  in  1  datapath read strobe; driven by the datapath's IF buffer read output.
- rd_data  out  DATA_WIDTH+2  head word as {start, end, data}.
- empty  out  1  no valid entry.
- count  out  ADDR_LEN+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers, count, column counter and sticky flags go to 0.
  - Outputs: empty=1, full=0, count=0, rd_data=0, overflow=0, underflow=0.
  - Memory contents need not be cleared.
  - Reset asserted mid-stream discards all content immediately.
- Tagging, on each accepted write:
  - start = (col==0).
  - end = (col==eff_len-1).
  - col increments, and wraps to 0 after the end word.
  - eff_len is the row_len value latched when col==0, so a row_len change takes effect only at the next row boundary.
  - row_len==0 is treated as 1: every word has start=1 and end=1.
- Storage: entry written = {start, end, wr_data}.
  - Bit DATA_WIDTH is the end flag; the datapath consumes it as its end-of-IF flag.
  - Bit DATA_WIDTH+1 is the start flag.
- Read side, first-word-fall-through:
  - rd_data = mem[rd_ptr] while not empty; all zeros while empty.
  - The downstream zero-detect treats all-zero input as a stall, so the empty case reads as a stall.
  - rd_en with empty=0 pops the head at the clock edge; the next word is visible on rd_data the following cycle.
- Write acceptance: wr_en & ~full. A write while full is dropped and sets overflow; col does not advance.
- Read acceptance: rd_en & ~empty. A read while empty is ignored and sets underflow.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both accepted, count unchanged.
  - Full: read accepted, write dropped (no same-cycle slot reuse), overflow set.
  - Empty: write accepted, read ignored (no bypass), underflow set.
- Pointer wrap: ADDR_LEN-bit pointers wrap at DEPTH.
  - count tracks occupancy.
  - full = (count==DEPTH), empty = (count==0); both are registered-state derived, with no combinational path from wr_en/rd_en.
- clr (synchronous): has priority over wr_en/rd_en in the same cycle. It empties the FIFO, zeroes col and clears overflow/underflow. row_len is re-latched on the next write.
- Latency: a write at edge N is visible on rd_data and empty=0 after edge N.

Decomposition:
- Shared package holds:
  - the tag bit positions: END_BIT = DATA_WIDTH, START_BIT = DATA_WIDTH+1;
  - the tagged-word width: DATA_WIDTH+2;
  - default DEPTH/ADDR_LEN, shared with the datapath's IF scratch parameters.
- One natural sub-module, if_row_tagger: the col counter, row_len latch and start/end generation. The top level holds the memory, pointers, count and flags.

Test Plan:
- Reset behaviour: drive rst=0 mid-stream with count=5 -> empty=1, count=0, rd_data=0 asynchronously, before the next edge.
- Tagging: row_len=3; write 0x11,0x22,0x33,0x44 -> read order {1,0,0x11},{0,0,0x22},{0,1,0x33},{1,0,0x44}.
- Row-length change: row_len=4; write 2 words; change row_len to 2; write 4 words -> end tag on word 4 and word 6, start tag on words 1 and 5.
- row_len=0: write 0xAAAA -> rd_data={1,1,0xAAAA}.
- Fill and overflow: 16 writes -> full=1, count=16.
  - A 17th write is dropped and overflow=1.
  - Then 16 reads return the data in order across the pointer wrap, ending with empty=1.
- Simultaneous events:
  - Full with rd_en and wr_en together -> count=15, write lost, overflow=1.
  - Empty with rd_en and wr_en together -> count=1, underflow=1.
  - clr together with wr_en -> count=0, flags cleared.
